// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stage sequencer: state encodings and the
// per-stage control bundle.
package pipeline_ctrl_pkg;

  localparam logic [1:0] CTRL_RESET = 2'd0;
  localparam logic [1:0] CTRL_RUN   = 2'd1;
  localparam logic [1:0] CTRL_DWAIT = 2'd2;

  typedef struct packed {
    logic if_rst;
    logic if_en;
    logic id_rst;
    logic id_en;
    logic exe_rst;
    logic exe_en;
    logic mem_rst;
    logic mem_en;
    logic wb_en;
  } stage_ctl_t;

  // Uniform control word: every stage gets the same rst/en pair.
  function automatic stage_ctl_t ctl_uniform(input logic rst_v, input logic en_v);
    stage_ctl_t c;
    c.if_rst  = rst_v;
    c.if_en   = en_v;
    c.id_rst  = rst_v;
    c.id_en   = en_v;
    c.exe_rst = rst_v;
    c.exe_en  = en_v;
    c.mem_rst = rst_v;
    c.mem_en  = en_v;
    c.wb_en   = en_v;
    return c;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Handshake and stage-control bundle between the stage sequencer (master) and
// the 5-stage datapath / memories (slave).
interface pipeline_ctrl_if #(
  parameter int CNT_BITS = 32
);
  logic                inst_ren;
  logic                inst_ack;
  logic                reg_stall;
  logic                mem_valid;
  logic                mem_ren;
  logic                mem_wen;
  logic                mem_ack;
  logic                exception;
  logic                if_rst;
  logic                if_en;
  logic                id_rst;
  logic                id_en;
  logic                exe_rst;
  logic                exe_en;
  logic                mem_rst;
  logic                mem_en;
  logic                wb_en;
  logic                ready;
  logic                bus_timeout;
  logic [CNT_BITS-1:0] stall_cnt;

  modport master (
    input  inst_ren, inst_ack, reg_stall, mem_valid, mem_ren, mem_wen, mem_ack, exception,
    output if_rst, if_en, id_rst, id_en, exe_rst, exe_en, mem_rst, mem_en, wb_en,
    output ready, bus_timeout, stall_cnt
  );

  modport slave (
    output inst_ren, inst_ack, reg_stall, mem_valid, mem_ren, mem_wen, mem_ack, exception,
    input  if_rst, if_en, id_rst, id_en, exe_rst, exe_en, mem_rst, mem_en, wb_en,
    input  ready, bus_timeout, stall_cnt
  );
endinterface

// File: rtl/pipeline_ctrl_bus_watchdog.sv
// Data-bus watchdog: counts consecutive wait cycles, expire marks the last
// allowed cycle (count == MEM_TIMEOUT-1).
module pipeline_ctrl_bus_watchdog #(
  parameter int MEM_TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic expire
);
  localparam int W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

  logic [W-1:0] wdog;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wdog <= '0;
    end else if (inc) begin
      wdog <= wdog + W'(1);
    end
  end

  assign expire = (wdog == W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/pipeline_ctrl.sv
// Stage sequencer for the 5-stage MIPS datapath: drives every stage rst/en pair
// and wb_en, resolving reset, data wait, exception flush, load-use and fetch wait.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int RST_CYCLES  = 2,
  parameter int MEM_TIMEOUT = 256,
  parameter int CNT_BITS    = 32
) (
  input  logic             clk,
  input  logic             rst,
  pipeline_ctrl_if.master  bus
);
  localparam int RC_W = (RST_CYCLES > 2) ? $clog2(RST_CYCLES) : 1;

  logic [1:0]          state;
  logic [1:0]          state_nxt;
  logic                exc_pend;
  logic                exc_pend_nxt;
  logic [RC_W-1:0]     rst_cnt;
  logic [CNT_BITS-1:0] stall_cnt;
  stage_ctl_t          ctl;
  logic                dstall;
  logic                expire;
  logic                timeout;
  logic                wd_inc;
  logic                bus_to;
  logic                ready;
  logic                rst_done;

  assign dstall   = bus.mem_valid & (bus.mem_ren | bus.mem_wen) & ~bus.mem_ack;
  assign timeout  = (state == CTRL_DWAIT) & expire & dstall;
  assign ready    = (state != CTRL_RESET);
  assign rst_done = (rst_cnt == RC_W'(RST_CYCLES - 1));

  pipeline_ctrl_bus_watchdog #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .inc    (wd_inc),
    .clr    (~wd_inc),
    .expire (expire)
  );

  // Timeout is checked ahead of dstall: it is the one wait cycle that gives up.
  always_comb begin
    ctl          = ctl_uniform(1'b0, 1'b0);
    bus_to       = 1'b0;
    wd_inc       = 1'b0;
    exc_pend_nxt = exc_pend;
    state_nxt    = state;
    case (state)
      CTRL_RUN, CTRL_DWAIT: begin
        state_nxt = CTRL_RUN;
        if (timeout) begin
          bus_to       = 1'b1;
          ctl.id_rst   = 1'b1;
          ctl.exe_rst  = 1'b1;
          ctl.mem_rst  = 1'b1;
          exc_pend_nxt = exc_pend | bus.exception;
        end else if (dstall) begin
          state_nxt    = CTRL_DWAIT;
          wd_inc       = 1'b1;
          exc_pend_nxt = exc_pend | bus.exception;
        end else if (bus.exception || exc_pend) begin
          ctl.id_rst   = 1'b1;
          ctl.exe_rst  = 1'b1;
          ctl.mem_rst  = 1'b1;
          ctl.if_en    = 1'b1;
          exc_pend_nxt = 1'b0;
        end else if (bus.reg_stall) begin
          ctl.exe_rst  = 1'b1;
          ctl.mem_en   = 1'b1;
          ctl.wb_en    = 1'b1;
        end else if (bus.inst_ren && !bus.inst_ack) begin
          ctl.id_rst   = 1'b1;
          ctl.exe_en   = 1'b1;
          ctl.mem_en   = 1'b1;
          ctl.wb_en    = 1'b1;
        end else begin
          ctl = ctl_uniform(1'b0, 1'b1);
        end
      end
      default: begin
        ctl       = ctl_uniform(1'b1, 1'b0);
        state_nxt = ((state == CTRL_RESET) && rst_done) ? CTRL_RUN : CTRL_RESET;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CTRL_RESET;
      exc_pend  <= 1'b0;
      rst_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      state    <= state_nxt;
      exc_pend <= exc_pend_nxt;
      if (state == CTRL_RESET && !rst_done) begin
        rst_cnt <= rst_cnt + RC_W'(1);
      end
      if (ready && !ctl.if_en) begin
        stall_cnt <= stall_cnt + CNT_BITS'(1);
      end
    end
  end

  assign bus.if_rst      = ctl.if_rst;
  assign bus.if_en       = ctl.if_en;
  assign bus.id_rst      = ctl.id_rst;
  assign bus.id_en       = ctl.id_en;
  assign bus.exe_rst     = ctl.exe_rst;
  assign bus.exe_en      = ctl.exe_en;
  assign bus.mem_rst     = ctl.mem_rst;
  assign bus.mem_en      = ctl.mem_en;
  assign bus.wb_en       = ctl.wb_en;
  assign bus.ready       = ready;
  assign bus.bus_timeout = bus_to;
  assign bus.stall_cnt   = stall_cnt;

endmodule
